// File: rtl/softusb_iodebug.sv
// softusb_iodebug: navre IO-bus peripheral that gives firmware a byte FIFO
// to an external valid/ready sink and a 16-bit cycle timer whose two bytes
// read back coherently.
module softusb_iodebug #(
    parameter logic [5:0]  csr_base        = 6'h20,
    parameter int unsigned fifo_depth_log2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [5:0] io_a,
    input  logic [7:0] io_do,
    output logic [7:0] io_di,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       irq
);

    localparam int unsigned AW    = fifo_depth_log2;
    localparam int unsigned CW    = fifo_depth_log2 + 1;
    localparam int unsigned DEPTH = 1 << fifo_depth_log2;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_TLO    = 3'd2;
    localparam logic [2:0] REG_THI    = 3'd3;
    localparam logic [2:0] REG_TCTRL  = 3'd4;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          overflow;
    logic          irq_en;
    logic [15:0]   timer;
    logic          timer_en;
    logic [7:0]    shadow;

    logic [6:0]    addr_ext;
    logic [6:0]    base_ext;
    logic          sel_c;
    logic [2:0]    offset_c;
    logic          push_req_c;
    logic          wr_status_c;
    logic          wr_tctrl_c;
    logic          rd_lo_c;
    logic [7:0]    rd_data_c;
    logic          empty_c;
    logic          full_c;
    logic          push_c;
    logic          pop_c;
    logic          ovf_set_c;

    // Window decode in 7 bits so the window never wraps past 6'h3f.
    assign addr_ext = {1'b0, io_a};
    assign base_ext = {1'b0, csr_base};
    assign sel_c    = (addr_ext >= base_ext) && (addr_ext <= (base_ext + 7'd4));
    assign offset_c = 3'(io_a - csr_base);

    assign empty_c   = (count == '0);
    assign full_c    = (count == CW'(DEPTH));
    assign out_valid = ~empty_c;
    assign out_data  = mem[rd_ptr];

    // Register access decode and read-data mux.
    always_comb begin
        push_req_c  = 1'b0;
        wr_status_c = 1'b0;
        wr_tctrl_c  = 1'b0;
        rd_lo_c     = 1'b0;
        rd_data_c   = 8'h00;
        if (io_we && sel_c) begin
            case (offset_c)
                REG_DATA:   push_req_c  = 1'b1;
                REG_STATUS: wr_status_c = 1'b1;
                REG_TCTRL:  wr_tctrl_c  = 1'b1;
                default:    ;
            endcase
        end
        if (io_re && sel_c) begin
            case (offset_c)
                REG_STATUS: rd_data_c = {5'b0, overflow, empty_c, full_c};
                REG_TLO: begin
                    rd_data_c = timer[7:0];
                    rd_lo_c   = 1'b1;
                end
                REG_THI:    rd_data_c = shadow;
                REG_TCTRL:  rd_data_c = {7'b0, timer_en};
                default:    rd_data_c = 8'h00;
            endcase
        end
    end

    // FIFO handshake: fullness is judged before any same-cycle pop.
    always_comb begin
        push_c    = push_req_c & ~full_c;
        ovf_set_c = push_req_c & full_c;
        pop_c     = ~empty_c & out_ready;
        count_nxt = count;
        if (push_c && !pop_c) begin
            count_nxt = count + CW'(1);
        end else if (!push_c && pop_c) begin
            count_nxt = count - CW'(1);
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 8'h00;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= io_do;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
        end
    end

    // Sticky overflow (a new overflow beats a clear) and interrupt enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (ovf_set_c) begin
                overflow <= 1'b1;
            end else if (wr_status_c && io_do[2]) begin
                overflow <= 1'b0;
            end
            if (wr_status_c) begin
                irq_en <= io_do[3];
            end
        end
    end

    // Free-running timer; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer    <= 16'h0000;
            timer_en <= 1'b0;
        end else begin
            if (wr_tctrl_c && io_do[1]) begin
                timer <= 16'h0000;
            end else if (timer_en) begin
                timer <= timer + 16'd1;
            end
            if (wr_tctrl_c) begin
                timer_en <= io_do[0];
            end
        end
    end

    // High byte captured with the low-byte read so the pair is coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= 8'h00;
        end else if (rd_lo_c) begin
            shadow <= timer[15:8];
        end
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_di <= 8'h00;
            irq   <= 1'b0;
        end else begin
            io_di <= rd_data_c;
            irq   <= irq_en & ~empty_c;
        end
    end

endmodule

// File: tb/tb_softusb_iodebug.sv
// Directed bench for softusb_iodebug: FIFO, status flags, timer, decode, irq.
module tb_softusb_iodebug;

    localparam logic [5:0] BASE     = 6'h20;
    localparam logic [5:0] A_DATA   = BASE + 6'd0;
    localparam logic [5:0] A_STATUS = BASE + 6'd1;
    localparam logic [5:0] A_TLO    = BASE + 6'd2;
    localparam logic [5:0] A_THI    = BASE + 6'd3;
    localparam logic [5:0] A_TCTRL  = BASE + 6'd4;

    logic       clk;
    logic       rst;
    logic       io_re;
    logic       io_we;
    logic [5:0] io_a;
    logic [7:0] io_do;
    logic [7:0] io_di;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       irq;

    int errors = 0;
    int checks = 0;

    softusb_iodebug #(.csr_base(6'h20), .fifo_depth_log2(4)) dut (
        .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
        .io_do(io_do), .io_di(io_di), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the next negedge after the write edge.
    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        io_we = 1'b1; io_a = a; io_do = d;
        @(negedge clk);
        io_we = 1'b0; io_a = 6'h00; io_do = 8'h00;
    endtask

    // Called at a negedge; returns the registered read data one cycle later.
    task automatic io_read(input logic [5:0] a, output logic [7:0] v);
        io_re = 1'b1; io_a = a;
        @(negedge clk);
        io_re = 1'b0; io_a = 6'h00;
        v = io_di;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        io_write(A_DATA, 8'h55);
        io_write(A_STATUS, 8'h08);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || irq !== 1'b1) begin
            errors++; $display("FAIL pre_reset: valid=%b irq=%b, need 1 1", out_valid, irq);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (io_di !== 8'h00 || out_valid !== 1'b0 || out_data !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: io_di=%h valid=%b data=%h irq=%b, need all 0",
                     io_di, out_valid, out_data, irq);
        end
        #14 rst = 1'b0;
        @(negedge clk);
        io_read(A_STATUS, v);
        checks++;
        if (v !== 8'h02) begin
            errors++; $display("FAIL reset_status: got %h need 02", v);
        end
        checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL reset_idle: valid=%b irq=%b need 0 0", out_valid, irq);
        end
    endtask

    task automatic test_basic();
        logic [7:0] v;
        logic [7:0] exp [3];
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
        for (int i = 0; i < 3; i++) io_write(A_DATA, exp[i]);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h41) begin
            errors++; $display("FAIL basic_head: valid=%b data=%h need 1 41", out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("FAIL basic_drain[%0d]: valid=%b data=%h need 1 %h", i, out_valid, out_data, exp[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_empty: valid=%b need 0", out_valid);
        end
        out_ready = 1'b0;
        io_read(A_STATUS, v);
        checks++;
        if (v !== 8'h02) begin
            errors++; $display("FAIL basic_status: got %h need 02", v);
        end
        @(negedge clk);
        checks++;
        if (io_di !== 8'h00) begin
            errors++; $display("FAIL io_di_idle: got %h need 00", io_di);
        end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] v;
        for (int i = 0; i < 16; i++) io_write(A_DATA, 8'(i));
        io_read(A_STATUS, v);
        checks++;
        if (v !== 8'h01) begin
            errors++; $display("FAIL fill_status: got %h need 01", v);
        end
        io_write(A_DATA, 8'hAA);
        io_read(A_STATUS, v);
        checks++;
        if (v !== 8'h05) begin
            errors++; $display("FAIL ovf_status: got %h need 05", v);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                errors++;
                $display("FAIL fill_drain[%0d]: valid=%b data=%h need 1 %h", i, out_valid, out_data, 8'(i));
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL fill_empty: valid=%b need 0", out_valid);
        end
        io_read(A_STATUS, v);
        checks++;
        if (v !== 8'h06) begin
            errors++; $display("FAIL ovf_sticky: got %h need 06", v);
        end
        io_write(A_STATUS, 8'h04);
        io_read(A_STATUS, v);
        checks++;
        if (v !== 8'h02) begin
            errors++; $display("FAIL ovf_clear: got %h need 02", v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        for (int i = 0; i < 16; i++) io_write(A_DATA, 8'h10 + 8'(i));
        io_we = 1'b1; io_a = A_DATA; io_do = 8'hBB; out_ready = 1'b1;
        @(negedge clk);
        io_we = 1'b0; io_a = 6'h00; io_do = 8'h00; out_ready = 1'b0;
        io_read(A_STATUS, v);
        checks++;
        if (v !== 8'h04) begin
            errors++; $display("FAIL full_pushpop_status: got %h need 04", v);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h11 + 8'(i)) begin
                errors++;
                $display("FAIL full_pushpop_drain[%0d]: valid=%b data=%h need 1 %h",
                         i, out_valid, out_data, 8'h11 + 8'(i));
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL full_pushpop_count: valid=%b need 0 after 15", out_valid);
        end
        io_write(A_STATUS, 8'h04);
        for (int i = 0; i < 5; i++) io_write(A_DATA, 8'h60 + 8'(i));
        io_we = 1'b1; io_a = A_DATA; io_do = 8'h65; out_ready = 1'b1;
        @(negedge clk);
        io_we = 1'b0; io_a = 6'h00; io_do = 8'h00; out_ready = 1'b0;
        io_read(A_STATUS, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL pushpop5_status: got %h need 00", v);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h61 + 8'(i)) begin
                errors++;
                $display("FAIL pushpop5_drain[%0d]: valid=%b data=%h need 1 %h",
                         i, out_valid, out_data, 8'h61 + 8'(i));
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL pushpop5_count: valid=%b need 0 after 5", out_valid);
        end
    endtask

    task automatic test_timer();
        logic [7:0] v;
        io_write(A_TCTRL, 8'h03);
        repeat (255) @(negedge clk);
        io_read(A_TLO, v);
        checks++;
        if (v !== 8'hff) begin
            errors++; $display("FAIL timer_lo_ff: got %h need ff", v);
        end
        repeat (10) @(negedge clk);
        io_read(A_THI, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL timer_hi_shadow: got %h need 00", v);
        end
        io_read(A_TCTRL, v);
        checks++;
        if (v !== 8'h01) begin
            errors++; $display("FAIL timer_ctrl_rd: got %h need 01", v);
        end
        io_write(A_TCTRL, 8'h03);
        io_read(A_TLO, v);
        checks++;
        if (v >= 8'h04) begin
            errors++; $display("FAIL timer_clear: got %h need < 04", v);
        end
        io_write(A_TCTRL, 8'h03);
        repeat (65534) @(negedge clk);
        io_read(A_TLO, v);
        checks++;
        if (v !== 8'hfe) begin
            errors++; $display("FAIL wrap_lo_fe: got %h need fe", v);
        end
        io_read(A_THI, v);
        checks++;
        if (v !== 8'hff) begin
            errors++; $display("FAIL wrap_hi_ff: got %h need ff", v);
        end
        io_read(A_TLO, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL wrap_lo_00: got %h need 00", v);
        end
        io_read(A_THI, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL wrap_hi_00: got %h need 00", v);
        end
        io_write(A_TCTRL, 8'h00);
    endtask

    task automatic test_addr_decode();
        logic [7:0] v;
        io_write(BASE - 6'd1, 8'hff);
        io_write(BASE + 6'd5, 8'hff);
        io_write(BASE + 6'd8, 8'hff);
        io_write(6'h00, 8'hff);
        io_read(A_STATUS, v);
        checks++;
        if (v !== 8'h02 || out_valid !== 1'b0) begin
            errors++; $display("FAIL decode_status: got %h valid=%b need 02 0", v, out_valid);
        end
        io_read(A_TLO, v);
        checks++;
        if (v !== 8'h03) begin
            errors++; $display("FAIL decode_timer: got %h need 03", v);
        end
        io_read(A_TCTRL, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL decode_tctrl: got %h need 00", v);
        end
        io_read(BASE - 6'd1, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL decode_rd_below: got %h need 00", v);
        end
        io_read(BASE + 6'd9, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL decode_rd_above: got %h need 00", v);
        end
        io_write(A_STATUS, 8'h08);
        io_write(A_DATA, 8'h77);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_rise: got %b need 1", irq);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (irq !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL irq_fall: irq=%b valid=%b need 0 0", irq, out_valid);
        end
    endtask

    initial begin
        rst = 1'b1; io_re = 1'b0; io_we = 1'b0; io_a = 6'h00; io_do = 8'h00; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill_overflow();
        test_back_to_back();
        test_timer();
        test_addr_decode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/softusb_iodebug.md
Name: softusb_iodebug

Overview:
- IO-bus responder peripheral for the softusb_navre core.
- Sits on the navre io_re/io_we/io_a/io_do/io_di port and decodes a 5-register window at a parameterised base address.
- Provides a byte FIFO from firmware to an external valid/ready sink, e.g. a debug console or a host-visible log.
- Also provides a 16-bit cycle timer whose two bytes read back atomically.

Parameters:
- csr_base, 6'h20, IO address of register 0; registers occupy csr_base..csr_base+4, with no wrap past 6'h3f.
- fifo_depth_log2, 4, FIFO holds 2**fifo_depth_log2 bytes.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- io_re  input  1  IO read strobe from navre
- io_we  input  1  IO write strobe from navre
- io_a  input  6  IO address
- io_do  input  8  write data from navre
- io_di  output  8  read data to navre; 0 when not selected
- out_valid  output  1  FIFO head byte available to sink
- out_data  output  8  FIFO head byte
- out_ready  input  1  sink accepts the head byte when high together with out_valid
- irq  output  1  level, high while FIFO non-empty and irq_en=1

Behaviour:
- Reset (async, any time): FIFO flushed (rd_ptr=wr_ptr=0, count=0), overflow=0, irq_en=0, timer=0, timer_en=0, shadow=0, io_di=0, out_valid=0, out_data=0, irq=0. Reset mid-transfer discards all queued bytes.
- Register map (offset from csr_base):
  - 0 DATA: write pushes io_do; read returns 0.
  - 1 STATUS: read {5'b0, overflow, empty, full}; write bit2=1 clears overflow; write bit3 sets irq_en=io_do[3].
  - 2 TIMER_LO: read returns timer[7:0] and, in the same cycle, latches timer[15:8] into shadow.
  - 3 TIMER_HI: read returns shadow.
  - 4 TIMER_CTRL: write bit0 sets timer_en; bit1=1 clears timer to 0 on the next edge (clear wins over increment). Read returns {7'b0, timer_en}.
- Read latency: io_di is registered. The value is sampled in the cycle io_re is high and appears after the next clk edge; this matches navre's one-cycle IO read timing.
- io_di returns to 0 one cycle after any io_re that missed the window, and 0 whenever io_re is low.
- io_re and io_we are never both high (navre guarantee). If they are, the write takes effect and the read data is still returned.
- Accesses outside the window have no effect.
- FIFO: circular buffer with a (fifo_depth_log2+1)-bit count; pointers wrap modulo depth.
  - full: count==depth. empty: count==0.
  - out_valid = ~empty. out_data = mem[rd_ptr], combinational from registered storage, stable while out_valid && ~out_ready.
  - Pop on out_valid && out_ready.
  - Push on a DATA write. If full (evaluated before any same-cycle pop), the byte is dropped, overflow is set, and a same-cycle pop still proceeds.
  - Push and pop in the same cycle when not full and not empty: count unchanged, both pointers advance.
  - Push to empty FIFO: out_valid rises the cycle after the write edge.
  - STATUS reflects the state registered before the current access.
- overflow: sticky until cleared by a STATUS write with bit2=1. A clear and a new overflow in the same cycle leave overflow=1.
- Timer: increments by 1 each clk when timer_en=1; 16-bit wrap 16'hffff->16'h0000. A TIMER_LO read followed by a TIMER_HI read always gives a coherent 16-bit value, even across wrap.
- irq = irq_en & ~empty, registered.

Test Plan:
- Reset then idle: assert rst mid-cycle for 15 ns -> all outputs 0 immediately (async); STATUS read returns 8'h02 (empty) one cycle after io_re.
- Push 3 bytes 8'h41,8'h42,8'h43 with out_ready=0 -> out_valid=1 and out_data=8'h41; then out_ready=1 -> 41,42,43 delivered on consecutive cycles, out_valid falls after the third, STATUS=8'h02.
- Fill 16 bytes (0..15) with out_ready=0 -> STATUS=8'h01. The 17th write (8'hAA) is dropped and STATUS=8'h05; drain yields 0..15 exactly; writing STATUS 8'h04 then reading returns 8'h02.
- Full FIFO, DATA write coinciding with out_ready=1 pop -> byte dropped, overflow=1, count becomes 15. Separately, with FIFO at count 5, simultaneous push/pop -> count stays 5 and order is preserved.
- Timer: preload by enabling until timer=16'h00ff, then read TIMER_LO -> 8'hff. Keep timer running 10 cycles, then read TIMER_HI -> 8'h00 (shadow, not 8'h01). Write TIMER_CTRL 8'h03 -> next TIMER_LO read is small (<4). Run from 16'hfffe -> wraps to 0.
- Address decode: writes to csr_base-1 and csr_base+5 (8'hff) -> no FIFO/timer/flag change, io_di=0 after reads there. With irq_en set via STATUS 8'h08, a single push raises irq and a pop drops it.
